// File: rtl/rv32_pkg.sv
// Shared RV32I load/store constants and the data-memory sequencer state type.
package rv32_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte enables and replication, misalignment
// detection, and load lane extraction with sign/zero extension.
module lsu_align
    import rv32_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_off,
    input  logic        is_store,
    input  logic [31:0] st_wdata,
    output logic [3:0]  be,
    output logic [31:0] lane_wdata,
    output logic        misaligned,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] rdata,
    output logic [31:0] load_data
);

    logic [7:0]  rbyte [4];
    logic [7:0]  sel_b;
    logic [15:0] sel_h;

    for (genvar gi = 0; gi < 4; gi++) begin : g_rbyte
        assign rbyte[gi] = rdata[8*gi +: 8];
    end

    assign sel_b = rbyte[ld_off];
    // Halfword loads are always 2-byte aligned, so only the upper offset bit matters.
    assign sel_h = ld_off[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        load_data = rdata;
        case (ld_funct3)
            F3_B:    load_data = {{24{sel_b[7]}}, sel_b};
            F3_BU:   load_data = {24'b0, sel_b};
            F3_H:    load_data = {{16{sel_h[15]}}, sel_h};
            F3_HU:   load_data = {16'b0, sel_h};
            default: load_data = rdata;
        endcase
    end

    always_comb begin
        be         = 4'b1111;
        lane_wdata = st_wdata;
        misaligned = 1'b0;
        case (st_funct3)
            F3_B, F3_BU: begin
                be         = 4'b0001 << st_off;
                lane_wdata = {4{st_wdata[7:0]}};
            end
            F3_H, F3_HU: begin
                be         = 4'b0011 << st_off;
                lane_wdata = {2{st_wdata[15:0]}};
                misaligned = st_off[0];
            end
            default: begin
                be         = 4'b1111;
                lane_wdata = st_wdata;
                misaligned = |st_off;
            end
        endcase
        // Loads fetch the whole word and pick the lane on return.
        if (!is_store) begin
            be = 4'b1111;
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Load/store sequencer between EX/MEM and a valid/ready data-memory bus;
// stalls the pipeline for the duration of each access and times out stuck buses.
module dmem_ctrl
    import rv32_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic        req_re,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata,
    output logic        stall,
    output logic        mem_re,
    output logic [31:0] mem_data_out,
    output logic        misalign,
    output logic        bus_err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [1:0]        off_reg, off_next;
    logic [2:0]        f3_reg, f3_next;
    logic              load_reg, load_next;

    logic              bus_req_reg, bus_req_next;
    logic              bus_we_reg, bus_we_next;
    logic [31:0]       bus_addr_reg, bus_addr_next;
    logic [3:0]        bus_be_reg, bus_be_next;
    logic [31:0]       bus_wdata_reg, bus_wdata_next;
    logic              mem_re_reg, mem_re_next;
    logic [31:0]       mem_data_reg, mem_data_next;
    logic              misalign_reg, misalign_next;
    logic              bus_err_reg, bus_err_next;

    logic              is_store;
    logic              misaligned;
    logic              can_accept;
    logic [3:0]        be;
    logic [31:0]       lane_wdata;
    logic [31:0]       load_data;

    // A request with both we and re set is treated as a store.
    assign is_store   = req_we;
    assign can_accept = (state_reg == IDLE) || (state_reg == DONE);

    lsu_align u_align (
        .st_funct3  (funct3),
        .st_off     (addr[1:0]),
        .is_store   (is_store),
        .st_wdata   (wdata),
        .be         (be),
        .lane_wdata (lane_wdata),
        .misaligned (misaligned),
        .ld_funct3  (f3_reg),
        .ld_off     (off_reg),
        .rdata      (bus_rdata),
        .load_data  (load_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            off_reg       <= 2'b00;
            f3_reg        <= 3'b000;
            load_reg      <= 1'b0;
            bus_req_reg   <= 1'b0;
            bus_we_reg    <= 1'b0;
            bus_addr_reg  <= 32'h0;
            bus_be_reg    <= 4'h0;
            bus_wdata_reg <= 32'h0;
            mem_re_reg    <= 1'b0;
            mem_data_reg  <= 32'h0;
            misalign_reg  <= 1'b0;
            bus_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            off_reg       <= off_next;
            f3_reg        <= f3_next;
            load_reg      <= load_next;
            bus_req_reg   <= bus_req_next;
            bus_we_reg    <= bus_we_next;
            bus_addr_reg  <= bus_addr_next;
            bus_be_reg    <= bus_be_next;
            bus_wdata_reg <= bus_wdata_next;
            mem_re_reg    <= mem_re_next;
            mem_data_reg  <= mem_data_next;
            misalign_reg  <= misalign_next;
            bus_err_reg   <= bus_err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        off_next       = off_reg;
        f3_next        = f3_reg;
        load_next      = load_reg;
        bus_req_next   = bus_req_reg;
        bus_we_next    = bus_we_reg;
        bus_addr_next  = bus_addr_reg;
        bus_be_next    = bus_be_reg;
        bus_wdata_next = bus_wdata_reg;
        mem_re_next    = mem_re_reg;
        mem_data_next  = mem_data_reg;
        misalign_next  = 1'b0;
        bus_err_next   = 1'b0;

        unique case (state_reg)
            IDLE, DONE: begin
                // The result is only presented for the single DONE cycle.
                state_next  = IDLE;
                mem_re_next = 1'b0;
                if (req_valid) begin
                    if (misaligned) begin
                        misalign_next = 1'b1;
                    end else begin
                        state_next     = ACCESS;
                        cnt_next       = '0;
                        off_next       = addr[1:0];
                        f3_next        = funct3;
                        load_next      = ~is_store;
                        bus_req_next   = 1'b1;
                        bus_we_next    = is_store;
                        bus_addr_next  = {addr[31:2], 2'b00};
                        bus_be_next    = be;
                        bus_wdata_next = lane_wdata;
                    end
                end
            end
            ACCESS: begin
                if (bus_ready) begin
                    bus_req_next = 1'b0;
                    state_next   = DONE;
                    if (load_reg) begin
                        mem_re_next   = 1'b1;
                        mem_data_next = load_data;
                    end
                end else if (cnt_reg == CNT_LAST) begin
                    // Abort: loads still complete, returning zero.
                    bus_req_next = 1'b0;
                    bus_err_next = 1'b1;
                    state_next   = DONE;
                    if (load_reg) begin
                        mem_re_next   = 1'b1;
                        mem_data_next = 32'h0;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign stall = (can_accept && req_valid && !misaligned) || (state_reg == ACCESS);

    assign bus_req      = bus_req_reg;
    assign bus_we       = bus_we_reg;
    assign bus_addr     = bus_addr_reg;
    assign bus_be       = bus_be_reg;
    assign bus_wdata    = bus_wdata_reg;
    assign mem_re       = mem_re_reg;
    assign mem_data_out = mem_data_reg;
    assign misalign     = misalign_reg;
    assign bus_err      = bus_err_reg;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: expected load results are queued when a
// request is driven and popped when the access completes.
module tb_dmem_ctrl;
    import rv32_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic        req_re = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ready = 1'b0;
    logic [31:0] bus_rdata = 32'h0;
    logic        stall;
    logic        mem_re;
    logic [31:0] mem_data_out;
    logic        misalign;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        mem_re;
        logic [31:0] data;
        logic        err;
    } exp_t;

    typedef struct {
        int          stall_cyc;
        int          req_cyc;
        logic        stable;
        logic        done;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        we;
        logic        mem_re;
        logic [31:0] data;
        logic        err;
        logic        mis;
    } obs_t;

    exp_t sb[$];

    dmem_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_re       (req_re),
        .funct3       (funct3),
        .addr         (addr),
        .wdata        (wdata),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_be       (bus_be),
        .bus_wdata    (bus_wdata),
        .bus_ready    (bus_ready),
        .bus_rdata    (bus_rdata),
        .stall        (stall),
        .mem_re       (mem_re),
        .mem_data_out (mem_data_out),
        .misalign     (misalign),
        .bus_err      (bus_err)
    );

    always #5 clk = ~clk;

    task automatic drive_req(input logic we, input logic re, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd);
        req_valid = 1'b1;
        req_we    = we;
        req_re    = re;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
    endtask

    task automatic idle_req();
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_re    = 1'b0;
    endtask

    // Drives one request and observes it to completion; no comparisons here.
    task automatic run_access(input logic we, input logic re, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              input int waits, input logic [31:0] rd, output obs_t o);
        o = '{default: 0};
        o.stable = 1'b1;
        @(negedge clk);
        drive_req(we, re, f3, a, wd);
        #1 if (stall) o.stall_cyc++;
        @(negedge clk);
        idle_req();
        o.mis  = misalign;
        o.addr = bus_addr;
        o.be   = bus_be;
        o.wd   = bus_wdata;
        o.we   = bus_we;
        for (int c = 0; c < 64 && bus_req; c++) begin
            o.req_cyc++;
            if ({bus_addr, bus_be, bus_wdata, bus_we} != {o.addr, o.be, o.wd, o.we})
                o.stable = 1'b0;
            bus_ready = (c >= waits);
            bus_rdata = (c >= waits) ? rd : $urandom;
            #1 if (stall) o.stall_cyc++;
            @(negedge clk);
        end
        bus_ready = 1'b0;
        o.done   = !bus_req;
        o.mem_re = mem_re;
        o.data   = mem_data_out;
        o.err    = bus_err;
        #1 if (stall) o.stall_cyc++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({bus_req, bus_we, bus_addr, bus_be, bus_wdata, mem_re, mem_data_out,
             misalign, bus_err, stall} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got req=%b we=%b addr=%h be=%h wd=%h re=%b d=%h mis=%b err=%b stall=%b exp all 0",
                     bus_req, bus_we, bus_addr, bus_be, bus_wdata, mem_re, mem_data_out, misalign, bus_err, stall);
        end
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset released");
    endtask

    task automatic test_word_load();
        obs_t o;
        exp_t e;
        sb.push_back('{1'b1, 32'hDEADBEEF, 1'b0});
        run_access(1'b0, 1'b1, F3_W, 32'h100, 32'h0, 0, 32'hDEADBEEF, o);
        e = sb.pop_front();
        checks++;
        if (o.addr !== 32'h100 || o.be !== 4'hF || o.we !== 1'b0) begin
            errors++;
            $display("FAIL lw_bus got addr=%h be=%h we=%b exp addr=00000100 be=f we=0", o.addr, o.be, o.we);
        end
        checks++;
        if (o.stall_cyc !== 2 || o.req_cyc !== 1) begin
            errors++;
            $display("FAIL lw_timing got stall=%0d req=%0d exp stall=2 req=1", o.stall_cyc, o.req_cyc);
        end
        checks++;
        if (o.mem_re !== e.mem_re || o.data !== e.data || o.err !== e.err) begin
            errors++;
            $display("FAIL lw_result got re=%b data=%h err=%b exp re=%b data=%h err=%b",
                     o.mem_re, o.data, o.err, e.mem_re, e.data, e.err);
        end
        @(negedge clk);
        checks++;
        if (mem_re !== 1'b0) begin
            errors++;
            $display("FAIL lw_mem_re_clear got %b exp 0", mem_re);
        end
        $display("LW  addr=00000100 data=%h stall=%0d", o.data, o.stall_cyc);
    endtask

    task automatic test_sub_loads();
        logic [2:0]  f3s  [4] = '{F3_B, F3_BU, F3_H, F3_HU};
        logic [31:0] adrs [4] = '{32'h103, 32'h103, 32'h102, 32'h102};
        logic [31:0] rds  [4] = '{32'h80A5C33C, 32'h80A5C33C, 32'h8001C33C, 32'h8001C33C};
        logic [31:0] exps [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001};
        obs_t o;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{1'b1, exps[i], 1'b0});
            run_access(1'b0, 1'b1, f3s[i], adrs[i], 32'h0, i, rds[i], o);
            e = sb.pop_front();
            checks++;
            if (o.mem_re !== e.mem_re || o.data !== e.data || o.addr !== {adrs[i][31:2], 2'b00}) begin
                errors++;
                $display("FAIL subload_%0d got re=%b data=%h addr=%h exp re=1 data=%h",
                         i, o.mem_re, o.data, o.addr, e.data);
            end
            $display("LD f3=%b addr=%h data=%h", f3s[i], adrs[i], o.data);
        end
    endtask

    task automatic test_stores();
        logic [2:0]  f3s  [3] = '{F3_H, F3_B, F3_W};
        logic [31:0] adrs [3] = '{32'h42, 32'h41, 32'h3C};
        logic [31:0] wds  [3] = '{32'h1234ABCD, 32'hCAFE0077, 32'h13579BDF};
        int          wts  [3] = '{3, 0, 1};
        logic [3:0]  ebe  [3] = '{4'b1100, 4'b0010, 4'b1111};
        logic [31:0] ewd  [3] = '{32'hABCDABCD, 32'h77777777, 32'h13579BDF};
        logic [31:0] prev;
        obs_t o;
        prev = mem_data_out;
        for (int i = 0; i < 3; i++) begin
            run_access(1'b1, (i == 1), f3s[i], adrs[i], wds[i], wts[i], $urandom, o);
            checks++;
            if (o.addr !== {adrs[i][31:2], 2'b00} || o.be !== ebe[i] || o.wd !== ewd[i] || o.we !== 1'b1) begin
                errors++;
                $display("FAIL store_bus_%0d got addr=%h be=%b wd=%h we=%b exp be=%b wd=%h we=1",
                         i, o.addr, o.be, o.wd, o.we, ebe[i], ewd[i]);
            end
            checks++;
            if (!o.stable || o.req_cyc !== wts[i] + 1 || o.stall_cyc !== wts[i] + 2) begin
                errors++;
                $display("FAIL store_hold_%0d got stable=%b req=%0d stall=%0d exp stable=1 req=%0d stall=%0d",
                         i, o.stable, o.req_cyc, o.stall_cyc, wts[i] + 1, wts[i] + 2);
            end
            checks++;
            if (o.mem_re !== 1'b0 || o.data !== prev) begin
                errors++;
                $display("FAIL store_result_%0d got re=%b data=%h exp re=0 data=%h", i, o.mem_re, o.data, prev);
            end
            $display("ST f3=%b addr=%h be=%b wd=%h", f3s[i], adrs[i], o.be, o.wd);
        end
    endtask

    task automatic test_misaligned();
        logic [2:0]  f3s  [2] = '{F3_W, F3_H};
        logic [31:0] adrs [2] = '{32'h102, 32'h43};
        obs_t o;
        for (int i = 0; i < 2; i++) begin
            run_access((i == 1), (i == 0), f3s[i], adrs[i], 32'h5555AAAA, 0, 32'h0, o);
            checks++;
            if (o.mis !== 1'b1 || o.req_cyc !== 0 || o.stall_cyc !== 0) begin
                errors++;
                $display("FAIL misalign_%0d got mis=%b req=%0d stall=%0d exp mis=1 req=0 stall=0",
                         i, o.mis, o.req_cyc, o.stall_cyc);
            end
            @(negedge clk);
            checks++;
            if (misalign !== 1'b0 || bus_req !== 1'b0) begin
                errors++;
                $display("FAIL misalign_pulse_%0d got mis=%b req=%b exp 0 0", i, misalign, bus_req);
            end
            $display("MIS f3=%b addr=%h", f3s[i], adrs[i]);
        end
    endtask

    task automatic test_timeout();
        obs_t o;
        exp_t e;
        sb.push_back('{1'b1, 32'h0, 1'b1});
        run_access(1'b0, 1'b1, F3_W, 32'h200, 32'h0, 1000, 32'hFFFFFFFF, o);
        e = sb.pop_front();
        checks++;
        if (!o.done || o.req_cyc !== TO) begin
            errors++;
            $display("FAIL timeout_len got done=%b req=%0d exp done=1 req=%0d", o.done, o.req_cyc, TO);
        end
        checks++;
        if (o.err !== e.err || o.mem_re !== e.mem_re || o.data !== e.data) begin
            errors++;
            $display("FAIL timeout_result got err=%b re=%b data=%h exp err=1 re=1 data=%h",
                     o.err, o.mem_re, o.data, e.data);
        end
        @(negedge clk);
        checks++;
        if (bus_err !== 1'b0 || mem_re !== 1'b0 || stall !== 1'b0 || bus_req !== 1'b0) begin
            errors++;
            $display("FAIL timeout_idle got err=%b re=%b stall=%b req=%b exp 0 0 0 0", bus_err, mem_re, stall, bus_req);
        end
        $display("TIMEOUT addr=00000200 req_cycles=%0d", o.req_cyc);
    endtask

    task automatic test_reset_mid_access();
        @(negedge clk);
        drive_req(1'b0, 1'b1, F3_W, 32'h300, 32'h0);
        @(negedge clk);
        idle_req();
        checks++;
        if (bus_req !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_req_up got %b exp 1", bus_req);
        end
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (bus_req !== 1'b0 || stall !== 1'b0 || mem_re !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_drop got req=%b stall=%b re=%b exp 0 0 0", bus_req, stall, mem_re);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus_req !== 1'b0 || mem_re !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_idle got req=%b re=%b exp 0 0", bus_req, mem_re);
        end
        $display("RESET mid-access at addr=00000300");
    endtask

    task automatic test_back_to_back();
        exp_t e;
        @(negedge clk);
        sb.push_back('{1'b1, 32'h11112222, 1'b0});
        drive_req(1'b0, 1'b1, F3_W, 32'h400, 32'h0);
        @(negedge clk);
        idle_req();
        checks++;
        if (bus_req !== 1'b1 || bus_addr !== 32'h400) begin
            errors++;
            $display("FAIL b2b_first got req=%b addr=%h exp 1 00000400", bus_req, bus_addr);
        end
        bus_ready = 1'b1;
        bus_rdata = 32'h11112222;
        @(negedge clk);
        bus_ready = 1'b0;
        e = sb.pop_front();
        checks++;
        if (bus_req !== 1'b0 || mem_re !== e.mem_re || mem_data_out !== e.data) begin
            errors++;
            $display("FAIL b2b_done1 got req=%b re=%b data=%h exp 0 1 %h", bus_req, mem_re, mem_data_out, e.data);
        end
        sb.push_back('{1'b1, 32'hFFFFFFA5, 1'b0});
        drive_req(1'b0, 1'b1, F3_B, 32'h405, 32'h0);
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL b2b_stall_in_done got %b exp 1", stall);
        end
        @(negedge clk);
        idle_req();
        checks++;
        if (bus_req !== 1'b1 || bus_addr !== 32'h404 || mem_re !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second got req=%b addr=%h re=%b exp 1 00000404 0", bus_req, bus_addr, mem_re);
        end
        bus_ready = 1'b1;
        bus_rdata = 32'h0000A500;
        @(negedge clk);
        bus_ready = 1'b0;
        e = sb.pop_front();
        checks++;
        if (mem_re !== e.mem_re || mem_data_out !== e.data) begin
            errors++;
            $display("FAIL b2b_done2 got re=%b data=%h exp 1 %h", mem_re, mem_data_out, e.data);
        end
        $display("B2B loads 00000400 then 00000405 data=%h", mem_data_out);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_word_load();
        test_sub_loads();
        test_stores();
        test_misaligned();
        test_timeout();
        test_reset_mid_access();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d exp 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Load/store sequencer between the EX/MEM pipeline register and a single-port data-memory bus with a valid/ready handshake.
- Accepts one RV32I load or store per request and drives the bus until the access completes.
- Stalls the pipeline for the whole access.
- Produces the aligned, sign/zero-extended load word and the mem_re select that the pre-writeback mux consumes.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles bus_req may wait for bus_ready before the access is aborted with an error.
- CNT_W, 5: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- req_valid  in  1  MEM-stage instruction is a load or store.
- req_we  in  1  store.
- req_re  in  1  load.
- funct3  in  3  RV32I width/sign code.
- addr  in  32  byte address from the ALU.
- wdata  in  32  store data (rs2).
- bus_req  out  1  bus request.
- bus_we  out  1  bus write.
- bus_addr  out  32  word address, with bits [1:0] = 0.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-shifted store data.
- bus_ready  in  1  bus accepted/completed the transfer this cycle.
- bus_rdata  in  32  read word; valid when bus_ready=1 on a read.
- stall  out  1  freeze IF..MEM.
- mem_re  out  1  writeback selects memory data.
- mem_data_out  out  32  extended load result.
- misalign  out  1  one-cycle misaligned-access pulse.
- bus_err  out  1  one-cycle timeout pulse.

Behaviour:
- Reset: clk is the only clock; rst_n is synchronous and active-low.
  - While rst_n=0, on the clock edge: state=IDLE, counter=0, and all registered outputs clear (bus_req, bus_we, bus_addr, bus_be, bus_wdata, mem_re, mem_data_out, misalign, bus_err all 0).
  - Reset mid-access drops bus_req at that edge. No response is produced and the pending access is discarded.
- FSM has three states: IDLE, ACCESS, DONE.
- Request priority: if req_we and req_re are both set, it is treated as a store.
- Alignment check, evaluated in IDLE or DONE when req_valid=1:
  - Misaligned when a halfword access has addr[0]=1, or a word access has addr[1:0]!=0.
  - On misalignment: no bus cycle, misalign=1 for the next cycle, stall never asserted, state stays or returns to IDLE.
- Accept, in IDLE or DONE with req_valid=1 and the access aligned:
  - Next edge loads bus_req=1, bus_we, bus_addr={addr[31:2],2'b00}, bus_be and bus_wdata; state becomes ACCESS and counter=0.
- Byte enables and store data:
  - Byte: be=4'b0001<<addr[1:0], data = wdata[7:0] replicated ×4.
  - Half: be=4'b0011<<addr[1:0], data = wdata[15:0] replicated ×2.
  - Word: be=4'b1111, data = wdata.
  - Loads drive be=4'b1111.
- ACCESS:
  - bus_addr, bus_be, bus_we and bus_wdata are held stable while bus_req=1.
  - If bus_ready=1: next edge gives bus_req=0 and state=DONE. On a load, mem_data_out is captured from bus_rdata with alignment/extension applied and mem_re=1.
  - Else the counter increments. When counter==TIMEOUT_CYCLES-1 with no bus_ready: next edge gives bus_req=0, bus_err=1 pulse, and state=DONE. On a load, mem_data_out=0 and mem_re=1.
- DONE:
  - Lasts one cycle, during which the result is valid and stall=0 so the pipeline advances.
  - A new req_valid in DONE is accepted exactly as in IDLE, giving back-to-back accesses. Otherwise the next state is IDLE and mem_re clears.
- stall is combinational: it is 1 when (state∈{IDLE,DONE} and req_valid and aligned) or state==ACCESS.
- Latency: a zero-wait bus makes an access occupy 3 cycles (accept, ACCESS, DONE) with stall high for 2 cycles.
- Load extension, using byte offset a=addr[1:0] latched at accept:
  - LB / LBU: sign- or zero-extend rdata[8a+7:8a].
  - LH / LHU: same on the 16-bit lane.
  - LW: pass through.
- Stores leave mem_data_out unchanged and mem_re=0.

Decomposition:
- Shared package rv32_pkg holds:
  - funct3 constants: F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101.
  - The state typedef with IDLE, ACCESS, DONE.
- One sub-module, lsu_align: purely combinational.
  - Load-lane extraction and extension.
  - Store byte-enable and data replication.
  - Misalignment detection.
- The FSM, counter and output registers stay in dmem_ctrl.

Test Plan:
- Zero-wait word load:
  - Stimulus: LW, addr=0x100, bus_ready=1 on the first request cycle, bus_rdata=0xDEADBEEF.
  - Response: bus_addr=0x100, be=4'hF; stall high for 2 cycles; in DONE mem_re=1 and mem_data_out=0xDEADBEEF.
- Byte loads:
  - Stimulus: LB at addr=0x103 with rdata=0x80xxxxxx.
  - Response: mem_data_out=0xFFFFFF80. LBU under the same conditions gives 0x00000080.
- Halfword store with wait states:
  - Stimulus: SH, addr=0x42, wdata=0x1234ABCD, bus_ready delayed 3 cycles.
  - Response: bus_addr=0x40, be=4'b1100, bus_wdata=0xABCDABCD, all held for 4 cycles; stall high for 5 cycles; mem_re=0.
- Misaligned word:
  - Stimulus: LW at addr=0x102.
  - Response: misalign=1 for one cycle; bus_req never asserted; stall=0.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=4, bus_ready held low.
  - Response: bus_req high for 4 cycles; then bus_err pulses; mem_data_out=0; FSM returns to IDLE.
- Reset mid-ACCESS, then back-to-back:
  - Stimulus: rst_n=0 during ACCESS.
  - Response: bus_req=0 and state=IDLE next edge.
  - Stimulus: after reset, two consecutive loads.
  - Response: the second is accepted in DONE, with no idle cycle between bus requests.
